// File: rtl/avalon_gpio_ext.sv
// Avalon-MM GPIO port: per-bit direction, set/clear output access, synchronized
// inputs with maskable rise/fall edge capture and a level interrupt.
module avalon_gpio_ext #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_DIR      = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE     = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5,
        ADDR_RISE_EN  = 3'd6,
        ADDR_FALL_EN  = 3'd7
    } reg_addr_t;

    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    reg_addr_t         reg_addr;
    logic              wr;
    logic [WIDTH-1:0]  wdata;
    logic              unused_wdata;

    logic [WIDTH-1:0]  data_out;
    logic [WIDTH-1:0]  dir;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  prev_in;
    logic [2:0]        warm_cnt;
    logic              detect_en;

    logic [WIDTH-1:0]  edge_clear;
    logic [WIDTH-1:0]  edge_hit;
    logic [WIDTH-1:0]  edge_next;
    logic [WIDTH-1:0]  rd_value;
    logic [31:0]       rd_word;

    assign reg_addr     = reg_addr_t'(address);
    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign detect_en = (warm_cnt == WARM_MAX);

    // Synchronizer, previous-sample register and post-reset warm-up counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_in  <= '0;
            warm_cnt <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_in <= sync_in;
            if (warm_cnt != WARM_MAX) begin
                warm_cnt <= warm_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        edge_clear = '0;
        edge_hit   = '0;
        if (wr && reg_addr == ADDR_EDGE) begin
            edge_clear = wdata;
        end
        if (detect_en) begin
            edge_hit = (sync_in & ~prev_in & rise_en) | (~sync_in & prev_in & fall_en);
        end
        // A new edge wins over a simultaneous clear so nothing is lost.
        edge_next = (edge_capture & ~edge_clear) | edge_hit;
    end

    always_comb begin
        rd_value = '0;
        case (reg_addr)
            ADDR_DATA:                 rd_value = (dir & data_out) | (~dir & sync_in);
            ADDR_DIR:                  rd_value = dir;
            ADDR_IRQ_MASK:             rd_value = irq_mask;
            ADDR_EDGE:                 rd_value = edge_capture;
            ADDR_OUTSET, ADDR_OUTCLEAR: rd_value = data_out;
            ADDR_RISE_EN:              rd_value = rise_en;
            ADDR_FALL_EN:              rd_value = fall_en;
        endcase
        rd_word                = '0;
        rd_word[WIDTH-1:0]     = rd_value;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= RESET_OUT;
            dir          <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            readdata     <= '0;
        end else begin
            readdata     <= rd_word;
            edge_capture <= edge_next;
            if (wr) begin
                case (reg_addr)
                    ADDR_DATA:     data_out <= wdata;
                    ADDR_DIR:      dir      <= wdata;
                    ADDR_IRQ_MASK: irq_mask <= wdata;
                    ADDR_EDGE:     ;
                    ADDR_OUTSET:   data_out <= data_out | wdata;
                    ADDR_OUTCLEAR: data_out <= data_out & ~wdata;
                    ADDR_RISE_EN:  rise_en  <= wdata;
                    ADDR_FALL_EN:  fall_en  <= wdata;
                endcase
            end
        end
    end

    assign irq      = |(edge_capture & irq_mask);
    assign out_port = data_out;
    assign oe       = dir;

endmodule

// File: tb/tb_avalon_gpio_ext.sv
// Directed bench for avalon_gpio_ext (WIDTH=8, SYNC_STAGES=2, RESET_OUT=0):
// bus writes/reads, edge capture timing, collisions, warm-up and async reset.
module tb_avalon_gpio_ext;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_gpio_ext #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .RESET_OUT   (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        in_port    = 8'h00;
        #12;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        n_checks++; if (oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe: got 0x%02h expected 0x00", oe); end
        n_checks++; if (out_port !== 8'h00) begin n_fail++; $display("FAIL reset_out_port: got 0x%02h expected 0x00", out_port); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got 0x%08h expected 0x0", readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(5);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_edge_capture: got 0x%08h expected 0x0", d); end
    endtask

    task automatic test_out_setclr;
        logic [2:0]  addrs [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
        logic [31:0] exps  [4] = '{32'h30, 32'h0F, 32'hB0, 32'hB0};
        logic [31:0] d;
        in_port = 8'h30;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'hA5);
        bus_write(3'd4, 32'h10);
        bus_write(3'd5, 32'h05);
        n_checks++; if (oe !== 8'h0F) begin n_fail++; $display("FAIL setclr_oe: got 0x%02h expected 0x0F", oe); end
        n_checks++; if (out_port !== 8'hB0) begin n_fail++; $display("FAIL setclr_out_port: got 0x%02h expected 0xB0", out_port); end
        wait_cycles(3);
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], d);
            n_checks++;
            if (d !== exps[i]) begin
                n_fail++;
                $display("FAIL setclr_read_addr%0d: got 0x%08h expected 0x%08h", addrs[i], d, exps[i]);
            end
        end
        bus_write(3'd1, 32'hFFFF_FF0F);
        bus_read(3'd1, d);
        n_checks++; if (d !== 32'h0F) begin n_fail++; $display("FAIL setclr_upper_bits: got 0x%08h expected 0x0000000F", d); end
        in_port = 8'h00;
        wait_cycles(4);
    endtask

    task automatic test_rise_irq;
        logic [31:0] d;
        bus_write(3'd6, 32'h01);
        bus_write(3'd2, 32'h01);
        @(negedge clk);
        in_port[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_edgeN: got %0b expected 0", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_edgeN1: got %0b expected 0", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq_edgeN2: got %0b expected 1", irq); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL rise_capture: got 0x%08h expected 0x01", d); end
        bus_write(3'd3, 32'h01);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_cleared: got %0b expected 0", irq); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL rise_capture_cleared: got 0x%08h expected 0x00", d); end
    endtask

    task automatic test_fall_any;
        logic [31:0] d;
        @(negedge clk); in_port[1] = 1'b1;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL fall_rise_disabled: got 0x%08h expected 0x00", d); end
        bus_write(3'd7, 32'h02);
        @(negedge clk); in_port[1] = 1'b0;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL fall_capture: got 0x%08h expected 0x02", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fall_irq_masked: got %0b expected 0", irq); end
        bus_write(3'd6, 32'h03);
        @(negedge clk); in_port[1] = 1'b1;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL any_stays_captured: got 0x%08h expected 0x02", d); end
        bus_write(3'd3, 32'h02);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL any_cleared: got 0x%08h expected 0x00", d); end
        @(negedge clk); in_port[1] = 1'b0;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL any_fall: got 0x%08h expected 0x02", d); end
        bus_write(3'd3, 32'h02);
        @(negedge clk); in_port[1] = 1'b1;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL any_rise: got 0x%08h expected 0x02", d); end
        bus_write(3'd3, 32'h02);
        @(negedge clk); in_port[2] = 1'b1;
        wait_cycles(3);
        @(negedge clk); in_port[2] = 1'b0;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL pulse_disabled_bit2: got 0x%08h expected 0x00", d); end
        bus_read(3'd6, d);
        n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL rise_en_readback: got 0x%08h expected 0x03", d); end
        bus_read(3'd7, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL fall_en_readback: got 0x%08h expected 0x02", d); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        @(negedge clk); in_port[0] = 1'b0;
        wait_cycles(4);
        @(negedge clk); in_port[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd3, 32'h01);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collision_irq: got %0b expected 1", irq); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL collision_set_wins: got 0x%08h expected 0x01", d); end
        bus_write(3'd3, 32'h01);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL collision_clear_after: got %0b expected 0", irq); end
    endtask

    task automatic test_warmup;
        logic [31:0] d;
        @(negedge clk);
        in_port = 8'hFF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bus_write(3'd6, 32'hFF);
        wait_cycles(5);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL warmup_no_capture: got 0x%08h expected 0x00", d); end
        @(negedge clk); in_port[7] = 1'b0;
        wait_cycles(4);
        @(negedge clk); in_port[7] = 1'b1;
        wait_cycles(4);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h80) begin n_fail++; $display("FAIL warmup_then_detect: got 0x%08h expected 0x80", d); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        bus_write(3'd3, 32'hFF);
        @(negedge clk); in_port = 8'h00;
        wait_cycles(4);
        @(negedge clk); in_port = 8'h03;
        wait_cycles(4);
        bus_write(3'd0, 32'h55);
        bus_write(3'd1, 32'hFF);
        bus_write(3'd2, 32'h03);
        bus_read(3'd3, d);
        n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL arst_pre_capture: got 0x%08h expected 0x03", d); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL arst_pre_irq: got %0b expected 1", irq); end
        n_checks++; if (out_port !== 8'h55) begin n_fail++; $display("FAIL arst_pre_out_port: got 0x%02h expected 0x55", out_port); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %0b expected 0", irq); end
        n_checks++; if (oe !== 8'h00) begin n_fail++; $display("FAIL arst_oe: got 0x%02h expected 0x00", oe); end
        n_checks++; if (out_port !== 8'h00) begin n_fail++; $display("FAIL arst_out_port: got 0x%02h expected 0x00", out_port); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL arst_readdata: got 0x%08h expected 0x0", readdata); end
        #1 reset_n = 1'b1;
        for (int a = 1; a < 8; a++) begin
            bus_read(3'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL arst_reg_addr%0d: got 0x%08h expected 0x0", a, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_setclr();
        test_rise_irq();
        test_fall_any();
        test_collision();
        test_warmup();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
